// File: rtl/mem_bus_ctrl.sv
// Arbitrates instruction-fetch and data load/store requests onto a single
// Avalon-MM master port; one outstanding transfer at a time.
module mem_bus_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    input  logic        data_rd_req,
    input  logic        data_wr_req,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_byteenable,
    input  logic [31:0] data_writedata,
    output logic [31:0] fetch_rdata,
    output logic        fetch_valid,
    output logic [31:0] data_rdata,
    output logic        data_valid,
    output logic        stall,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic [31:0] readdata,
    input  logic        waitrequest
);

    typedef enum logic [2:0] {
        IDLE,
        DATA_RD,
        DATA_WR,
        FETCH,
        RESP
    } state_t;

    state_t      state, state_d;
    logic        resp_fetch, resp_fetch_d;
    logic [31:0] address_d, writedata_d, fetch_rdata_d, data_rdata_d;
    logic [3:0]  byteenable_d;
    logic        read_d, write_d, fetch_valid_d, data_valid_d;
    logic        data_pending, fetch_pending;

    // A requester still sees its own request high in the cycle its valid
    // pulses; that request is already complete and must not be re-issued.
    assign data_pending  = (data_rd_req | data_wr_req) & ~data_valid;
    assign fetch_pending = fetch_req & ~fetch_valid;

    assign stall = (state != IDLE) | data_pending | fetch_pending;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            resp_fetch  <= 1'b0;
            address     <= '0;
            read        <= 1'b0;
            write       <= 1'b0;
            byteenable  <= '0;
            writedata   <= '0;
            fetch_rdata <= '0;
            fetch_valid <= 1'b0;
            data_rdata  <= '0;
            data_valid  <= 1'b0;
        end else begin
            state       <= state_d;
            resp_fetch  <= resp_fetch_d;
            address     <= address_d;
            read        <= read_d;
            write       <= write_d;
            byteenable  <= byteenable_d;
            writedata   <= writedata_d;
            fetch_rdata <= fetch_rdata_d;
            fetch_valid <= fetch_valid_d;
            data_rdata  <= data_rdata_d;
            data_valid  <= data_valid_d;
        end
    end

    always_comb begin
        state_d       = state;
        resp_fetch_d  = resp_fetch;
        address_d     = address;
        read_d        = read;
        write_d       = write;
        byteenable_d  = byteenable;
        writedata_d   = writedata;
        fetch_rdata_d = fetch_rdata;
        data_rdata_d  = data_rdata;
        fetch_valid_d = 1'b0;
        data_valid_d  = 1'b0;

        case (state)
            IDLE: begin
                if (data_pending) begin
                    if (data_byteenable == '0) begin
                        // Misaligned access: complete locally, no bus cycle.
                        data_valid_d = 1'b1;
                        data_rdata_d = '0;
                    end else begin
                        address_d    = data_addr;
                        byteenable_d = data_byteenable;
                        if (data_wr_req) begin
                            write_d     = 1'b1;
                            writedata_d = data_writedata;
                            state_d     = DATA_WR;
                        end else begin
                            read_d  = 1'b1;
                            state_d = DATA_RD;
                        end
                    end
                end else if (fetch_pending) begin
                    address_d    = fetch_addr;
                    byteenable_d = 4'b1111;
                    read_d       = 1'b1;
                    state_d      = FETCH;
                end
            end

            DATA_WR: begin
                if (!waitrequest) begin
                    write_d      = 1'b0;
                    data_valid_d = 1'b1;
                    state_d      = IDLE;
                end
            end

            DATA_RD, FETCH: begin
                if (!waitrequest) begin
                    read_d       = 1'b0;
                    resp_fetch_d = (state == FETCH);
                    state_d      = RESP;
                end
            end

            RESP: begin
                if (resp_fetch) begin
                    fetch_rdata_d = readdata;
                    fetch_valid_d = 1'b1;
                end else begin
                    data_rdata_d = readdata;
                    data_valid_d = 1'b1;
                end
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: requester tasks push expected bus
// transfers and responses; a slave model and a response monitor pop and compare.
module tb_mem_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic        data_rd_req = 1'b0;
    logic        data_wr_req = 1'b0;
    logic [31:0] data_addr = '0;
    logic [3:0]  data_byteenable = '0;
    logic [31:0] data_writedata = '0;
    logic [31:0] fetch_rdata, data_rdata, address, writedata;
    logic        fetch_valid, data_valid, stall, read, write;
    logic [3:0]  byteenable;
    logic [31:0] readdata = '0;
    logic        waitrequest = 1'b0;

    mem_bus_ctrl dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .data_rd_req(data_rd_req), .data_wr_req(data_wr_req),
        .data_addr(data_addr), .data_byteenable(data_byteenable),
        .data_writedata(data_writedata),
        .fetch_rdata(fetch_rdata), .fetch_valid(fetch_valid),
        .data_rdata(data_rdata), .data_valid(data_valid), .stall(stall),
        .address(address), .read(read), .write(write),
        .byteenable(byteenable), .writedata(writedata),
        .readdata(readdata), .waitrequest(waitrequest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rdv;
        int unsigned cycles;
    } bus_t;

    typedef struct {
        logic        chk;
        logic [31:0] v;
    } rsp_t;

    bus_t        bus_q[$];
    rsp_t        data_q[$];
    logic [31:0] fetch_q[$];

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned slave_wait = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: event occurred, expected none", name);
    endtask

    // Avalon slave: inserts slave_wait wait states, checks each accepted transfer
    int unsigned wcnt = 0;
    int unsigned strobe_n = 0;
    logic [31:0] snap_addr, snap_wd;
    logic [3:0]  snap_be;
    logic        snap_rd, snap_wr;

    always @(negedge clk) begin
        if (reset || !(read || write)) begin
            waitrequest = 1'b0;
            wcnt = 0;
            strobe_n = 0;
        end else begin
            if (strobe_n == 0) begin
                snap_addr = address; snap_wd = writedata; snap_be = byteenable;
                snap_rd = read; snap_wr = write;
            end
            strobe_n++;
            if (wcnt < slave_wait) begin
                waitrequest = 1'b1;
                wcnt++;
            end else begin
                bus_t e;
                waitrequest = 1'b0;
                check("rw_exclusive", {31'b0, read & write}, 32'd0);
                if (bus_q.size() == 0) begin
                    flag("unexpected_bus_cycle");
                end else begin
                    e = bus_q.pop_front();
                    check("bus_write", {31'b0, write}, {31'b0, e.wr});
                    check("bus_read", {31'b0, read}, {31'b0, ~e.wr});
                    check("bus_addr", address, e.addr);
                    check("bus_be", {28'b0, byteenable}, {28'b0, e.be});
                    if (e.wr) check("bus_wdata", writedata, e.wd);
                    check("bus_held_addr", snap_addr, address);
                    check("bus_held_ctl", {snap_rd, snap_wr, snap_be, snap_wd},
                                          {read, write, byteenable, writedata});
                    check("bus_strobe_cycles", strobe_n, e.cycles);
                    readdata = e.rdv;
                end
                wcnt = 0;
                strobe_n = 0;
            end
        end
    end

    // Response monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (fetch_valid) begin
                if (fetch_q.size() == 0) flag("unexpected_fetch_valid");
                else check("fetch_rdata", fetch_rdata, fetch_q.pop_front());
            end
            if (data_valid) begin
                if (data_q.size() == 0) begin
                    flag("unexpected_data_valid");
                end else begin
                    rsp_t r;
                    r = data_q.pop_front();
                    if (r.chk) check("data_rdata", data_rdata, r.v);
                end
            end
        end
    end

    task automatic data_op(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [3:0] be, input logic [31:0] wd, input logic [31:0] rdv,
                           input int unsigned w, input int unsigned exp_lat);
        bus_t b;
        rsp_t r;
        int unsigned lat;
        bit seen;
        if (be != 4'b0000) begin
            b.wr = wr; b.addr = a; b.be = be; b.wd = wd; b.rdv = rdv; b.cycles = w + 1;
            bus_q.push_back(b);
        end
        r.chk = (be == 4'b0000) || !wr;
        r.v   = (be == 4'b0000) ? 32'h0 : rdv;
        data_q.push_back(r);
        slave_wait = w;
        @(posedge clk); #1;
        data_rd_req = rd; data_wr_req = wr; data_addr = a;
        data_byteenable = be; data_writedata = wd;
        seen = 0; lat = 0;
        for (int i = 1; i <= 200 && !seen; i++) begin
            @(posedge clk); @(negedge clk);
            if (data_valid) begin seen = 1; lat = i; end
        end
        data_rd_req = 1'b0; data_wr_req = 1'b0;
        if (!seen) flag("data_timeout");
        else check("data_latency", lat, exp_lat);
    endtask

    task automatic fetch_op(input logic [31:0] a, input logic [31:0] rdv,
                            input int unsigned w, input int unsigned exp_lat);
        bus_t b;
        int unsigned lat;
        bit seen;
        b.wr = 1'b0; b.addr = a; b.be = 4'b1111; b.wd = '0; b.rdv = rdv; b.cycles = w + 1;
        bus_q.push_back(b);
        fetch_q.push_back(rdv);
        slave_wait = w;
        @(posedge clk); #1;
        fetch_req = 1'b1; fetch_addr = a;
        seen = 0; lat = 0;
        for (int i = 1; i <= 200 && !seen; i++) begin
            @(posedge clk); @(negedge clk);
            if (fetch_valid) begin seen = 1; lat = i; end
        end
        fetch_req = 1'b0;
        if (!seen) flag("fetch_timeout");
        else check("fetch_latency", lat, exp_lat);
    endtask

    initial begin
        bus_t b;
        rsp_t r;
        bit done;

        repeat (2) @(posedge clk);
        #1;
        check("rst_read", {31'b0, read}, 32'd0);
        check("rst_write", {31'b0, write}, 32'd0);
        check("rst_addr", address, 32'h0);
        check("rst_be", {28'b0, byteenable}, 32'd0);
        check("rst_wdata", writedata, 32'h0);
        check("rst_valids", {30'b0, fetch_valid, data_valid}, 32'd0);
        check("rst_rdata", fetch_rdata | data_rdata, 32'h0);
        check("rst_stall", {31'b0, stall}, 32'd0);
        reset = 1'b0;

        fetch_op(32'hBFC0_0000, 32'h3C01_1234, 0, 3);
        data_op(1'b0, 1'b1, 32'h0000_0100, 4'b0011, 32'h0000_ABCD, 32'h0, 3, 5);
        data_op(1'b1, 1'b0, 32'h0000_0200, 4'b1111, 32'h0, 32'hDEAD_BEEF, 2, 5);
        fetch_op(32'hBFC0_0010, 32'h8C22_0004, 1, 4);
        @(negedge clk);
        check("data_rdata_hold", data_rdata, 32'hDEAD_BEEF);
        check("idle_stall", {31'b0, stall}, 32'd0);
        data_op(1'b1, 1'b0, 32'h0000_0204, 4'b0000, 32'h0, 32'h0, 0, 1);
        data_op(1'b1, 1'b1, 32'h0000_0104, 4'b1100, 32'hABCD_0000, 32'h0, 0, 2);

        // Simultaneous load and fetch: load first, stall until fetch completes
        b = '{wr: 1'b0, addr: 32'h80, be: 4'hF, wd: 32'h0, rdv: 32'h1111_2222, cycles: 1};
        bus_q.push_back(b);
        b = '{wr: 1'b0, addr: 32'hBFC0_0004, be: 4'hF, wd: 32'h0, rdv: 32'h2408_0005, cycles: 1};
        bus_q.push_back(b);
        r = '{chk: 1'b1, v: 32'h1111_2222};
        data_q.push_back(r);
        fetch_q.push_back(32'h2408_0005);
        slave_wait = 0;
        @(posedge clk); #1;
        data_rd_req = 1'b1; data_addr = 32'h80; data_byteenable = 4'hF;
        fetch_req = 1'b1; fetch_addr = 32'hBFC0_0004;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (fetch_valid) begin
                check("stall_at_last_valid", {31'b0, stall}, 32'd0);
                done = 1;
            end else begin
                check("stall_busy", {31'b0, stall}, 32'd1);
            end
            if (data_valid) data_rd_req = 1'b0;
            if (fetch_valid) fetch_req = 1'b0;
        end
        if (!done) flag("concurrent_timeout");
        data_rd_req = 1'b0; fetch_req = 1'b0;

        // Reset in the middle of a read held off by waitrequest
        slave_wait = 1000;
        @(posedge clk); #1;
        data_rd_req = 1'b1; data_addr = 32'h300; data_byteenable = 4'hF;
        @(posedge clk); #1;
        check("pre_rst_read", {31'b0, read}, 32'd1);
        @(posedge clk); @(negedge clk);
        check("pre_rst_wait", {31'b0, waitrequest}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_read", {31'b0, read}, 32'd0);
        check("mid_rst_addr", address, 32'h0);
        check("mid_rst_be", {28'b0, byteenable}, 32'd0);
        check("mid_rst_rdata", data_rdata | fetch_rdata, 32'h0);
        data_rd_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        slave_wait = 0;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_quiet", {29'b0, read, data_valid, fetch_valid}, 32'd0);
        end
        fetch_op(32'h0040_0000, 32'h1234_5678, 1, 4);

        repeat (3) @(negedge clk);
        check("bus_q_empty", bus_q.size(), 32'd0);
        check("data_q_empty", data_q.size(), 32'd0);
        check("fetch_q_empty", fetch_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
